// File: rtl/mccp_mem_pkg.sv
// Shared definitions for the MCCP memory-side protocol: FSM encoding and
// default widths used by the arbiter, the cores and the SoC top.
package mccp_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RESPOND = 2'd2
   } state_e;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_MEM_ADDR_W = 14;

   // Bits needed to index n items, never less than one.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester after last_i, wrapping.
module rr_picker
   import mccp_mem_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = idx_w(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] grant_o
);

   logic [IDX_W-1:0] cand;

   // Scan from the farthest candidate down so the nearest one after last_i wins.
   always_comb begin
      valid_o = 1'b0;
      grant_o = '0;
      cand    = '0;
      for (int k = N; k >= 1; k--) begin
         cand = IDX_W'((int'(last_i) + k) % N);
         if (req_i[cand]) begin
            valid_o = 1'b1;
            grant_o = cand;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin memory responder: serves one core's single-word read or write on
// a single-port RAM and returns a one-cycle response pulse with shared read data.
module mem_arbiter
   import mccp_mem_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int N_CORES     = 4,
   parameter int MEM_ADDR_W  = DEF_MEM_ADDR_W,
   parameter int MEM_LATENCY = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_CORES-1:0]         request,
   input  logic [N_CORES-1:0]         wren,
   input  logic [N_CORES*WIDTH-1:0]   address,
   input  logic [N_CORES*WIDTH-1:0]   writedata,
   output logic [N_CORES-1:0]         response,
   output logic [WIDTH-1:0]           readdata,
   output logic [MEM_ADDR_W-1:0]      mem_address,
   output logic [WIDTH-1:0]           mem_writedata,
   output logic                       mem_wren,
   input  logic [WIDTH-1:0]           mem_readdata
);

   localparam int IDX_W = idx_w(N_CORES);
   localparam int CNT_W = idx_w(MEM_LATENCY + 1);

   state_e                state_q;
   logic [IDX_W-1:0]      last_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [N_CORES-1:0]    response_q;
   logic [WIDTH-1:0]      readdata_q;
   logic [MEM_ADDR_W-1:0] mem_address_q;
   logic [WIDTH-1:0]      mem_writedata_q;
   logic                  mem_wren_q;

   logic                  pick_valid;
   logic [IDX_W-1:0]      pick;

   rr_picker #(.N(N_CORES), .IDX_W(IDX_W)) u_pick (
      .req_i   (request),
      .last_i  (last_q),
      .valid_o (pick_valid),
      .grant_o (pick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         last_q          <= IDX_W'(N_CORES - 1);
         cnt_q           <= '0;
         response_q      <= '0;
         readdata_q      <= '0;
         mem_address_q   <= '0;
         mem_writedata_q <= '0;
         mem_wren_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_valid) begin
                  // The granted core's address/data go straight into the RAM-facing registers.
                  last_q          <= pick;
                  cnt_q           <= CNT_W'(MEM_LATENCY);
                  mem_address_q   <= address[int'(pick)*WIDTH +: MEM_ADDR_W];
                  mem_writedata_q <= writedata[int'(pick)*WIDTH +: WIDTH];
                  mem_wren_q      <= wren[pick];
                  state_q         <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               mem_wren_q <= 1'b0;
               if (cnt_q == '0) begin
                  readdata_q <= mem_readdata;
                  response_q <= N_CORES'(1) << last_q;
                  state_q    <= ST_RESPOND;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_RESPOND: begin
               response_q <= '0;
               state_q    <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign response      = response_q;
   assign readdata      = readdata_q;
   assign mem_address   = mem_address_q;
   assign mem_writedata = mem_writedata_q;
   assign mem_wren      = mem_wren_q;

endmodule
